fetch_seq: RTL and testbench

FETCH_SEQ -- requirements
Module: fetch_seq

---
 rtl/fetch_seq.sv | 130 +++++++++++++
 tb/tb_fetch_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: walks the PC through sequential, branch and halt flow for the instruction ROM.
// Latency: start to first live fetch is one cycle; inst_addr_out, fetch_valid and halt come straight from registers.
// Backpressure: stall freezes PC, state and counters for that cycle. FETCH_SEQ_BRANCH_CT_EN enables the taken-branch counter.
module fetch_seq #(
  parameter int A  = 16,
  parameter int OV = 1000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [A-1:0] start_addr,
  input  logic         ctrl_branch,
  input  logic         take_branch,
  input  logic [7:0]   branch_offset,
  input  logic         stall,
  input  logic         halt_req,
  output logic [A-1:0] inst_addr_out,
  output logic         fetch_valid,
  output logic         halt,
  output logic [15:0]  cycle_ct,
  output logic [15:0]  branch_ct
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [A-1:0] PC_ONE  = {{(A-1){1'b0}}, 1'b1};
  localparam logic [31:0]  OV_LIM  = 32'(OV);
  localparam logic [15:0]  CT_MAX  = 16'hFFFF;

  state_t         state_q, state_d;
  logic [A-1:0]   pc_q, pc_d;
  logic [15:0]    cyc_q, cyc_d;
  logic [A-1:0]   offset_sx;
  logic [A-1:0]   next_pc;
  logic           br_taken;
  logic           advance;

  // Candidate next PC: relative branch when both branch strobes agree, else sequential.
  always_comb begin
    offset_sx = {{(A-8){branch_offset[7]}}, branch_offset};
    br_taken  = ctrl_branch && take_branch;
    next_pc   = br_taken ? (pc_q + offset_sx) : (pc_q + PC_ONE);
    advance   = (state_q == RUN) && !stall;
  end

  // Next-state and datapath selection; start wins over everything except reset.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cyc_d   = cyc_q;
    if (start) begin
      state_d = RUN;
      pc_d    = start_addr;
      cyc_d   = 16'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (!stall) begin
            if (cyc_q != CT_MAX) begin
              cyc_d = cyc_q + 16'd1;
            end
            if (halt_req) begin
              // halt instruction retires in place; PC stays on it
              state_d = HALTED;
            end else begin
              pc_d = next_pc;
              // running off the end of the program also halts, exposing the offending address
              if (32'(next_pc) >= OV_LIM) begin
                state_d = HALTED;
              end
            end
          end
        end
        IDLE:    state_d = IDLE;
        HALTED:  state_d = HALTED;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, PC and retire counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cyc_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cyc_q   <= cyc_d;
    end
  end

`ifdef FETCH_SEQ_BRANCH_CT_EN
  logic [15:0] br_q, br_d;

  // Taken-branch counter: counts only branches that actually redirect (halt suppresses them).
  always_comb begin
    br_d = br_q;
    if (start) begin
      br_d = 16'd0;
    end else if (advance && br_taken && !halt_req && (br_q != CT_MAX)) begin
      br_d = br_q + 16'd1;
    end
  end

  // Taken-branch counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      br_q <= 16'd0;
    end else begin
      br_q <= br_d;
    end
  end

  assign branch_ct = br_q;
`else
  assign branch_ct = 16'd0;
`endif

  assign inst_addr_out = pc_q;
  assign fetch_valid   = (state_q == RUN);
  assign halt          = (state_q == HALTED);
  assign cycle_ct      = cyc_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: reset, sequential fetch, branches, address-limit halt, stall and restart.
// Outputs sampled 1 time unit after each rising edge; inputs changed at the same point.
// Expected values are hand-computed constants; branch count expectation follows FETCH_SEQ_BRANCH_CT_EN.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] start_addr;
  logic        ctrl_branch;
  logic        take_branch;
  logic [7:0]  branch_offset;
  logic        stall;
  logic        halt_req;
  logic [15:0] inst_addr_out;
  logic        fetch_valid;
  logic        halt;
  logic [15:0] cycle_ct;
  logic [15:0] branch_ct;

  int n_checks = 0;
  int n_fails  = 0;

`ifdef FETCH_SEQ_BRANCH_CT_EN
  localparam int BR_EN = 1;
`else
  localparam int BR_EN = 0;
`endif

  fetch_seq #(.A(16), .OV(1000)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .start_addr    (start_addr),
    .ctrl_branch   (ctrl_branch),
    .take_branch   (take_branch),
    .branch_offset (branch_offset),
    .stall         (stall),
    .halt_req      (halt_req),
    .inst_addr_out (inst_addr_out),
    .fetch_valid   (fetch_valid),
    .halt          (halt),
    .cycle_ct      (cycle_ct),
    .branch_ct     (branch_ct)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] addr);
    start      = 1'b1;
    start_addr = addr;
    tick();
    start      = 1'b0;
  endtask

  function automatic logic [31:0] br_exp(input int n);
    return (BR_EN != 0) ? 32'(n) : 32'd0;
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; start_addr = '0; ctrl_branch = 1'b0;
    take_branch = 1'b0; branch_offset = '0; stall = 1'b0; halt_req = 1'b0;

    // reset state
    tick(); tick();
    check("rst_fv",   32'(fetch_valid),   32'd0);
    check("rst_halt", 32'(halt),          32'd0);
    check("rst_pc",   32'(inst_addr_out), 32'd0);
    check("rst_cyc",  32'(cycle_ct),      32'd0);
    check("rst_bct",  32'(branch_ct),     32'd0);
    reset = 1'b1;
    tick();
    check("idle_fv", 32'(fetch_valid), 32'd0);

    // sequential fetch from 0x0010
    launch(16'h0010);
    check("seq_fv0",  32'(fetch_valid),   32'd1);
    check("seq_pc0",  32'(inst_addr_out), 32'h10);
    check("seq_cyc0", 32'(cycle_ct),      32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("seq_pc",  32'(inst_addr_out), 32'(16'h10 + i));
      check("seq_cyc", 32'(cycle_ct),      32'(i));
    end
    tick();
    check("seq_cyc5", 32'(cycle_ct),    32'd5);
    check("seq_fv5",  32'(fetch_valid), 32'd1);

    // taken branches backward then forward
    launch(16'h0020);
    ctrl_branch = 1'b1; take_branch = 1'b1; branch_offset = 8'hFC;
    tick();
    check("br_back_pc",  32'(inst_addr_out), 32'h1C);
    check("br_back_bct", 32'(branch_ct),     br_exp(1));
    ctrl_branch = 1'b0; take_branch = 1'b0;
    repeat (4) tick();
    check("br_walk_pc", 32'(inst_addr_out), 32'h20);
    ctrl_branch = 1'b1; take_branch = 1'b1; branch_offset = 8'h05;
    tick();
    check("br_fwd_pc",  32'(inst_addr_out), 32'h25);
    check("br_fwd_bct", 32'(branch_ct),     br_exp(2));
    check("br_fwd_cyc", 32'(cycle_ct),      32'd6);

    // not-taken branch and stray take_branch
    launch(16'h0020);
    check("br_clr_bct", 32'(branch_ct), 32'd0);
    ctrl_branch = 1'b1; take_branch = 1'b0; branch_offset = 8'h05;
    tick();
    check("br_nt_pc", 32'(inst_addr_out), 32'h21);
    ctrl_branch = 1'b0; take_branch = 1'b1;
    tick();
    check("br_stray_pc",  32'(inst_addr_out), 32'h22);
    check("br_stray_bct", 32'(branch_ct),     32'd0);

    // halt_req beats a taken branch
    ctrl_branch = 1'b1; take_branch = 1'b1; halt_req = 1'b1;
    tick();
    check("hb_halt", 32'(halt),          32'd1);
    check("hb_fv",   32'(fetch_valid),   32'd0);
    check("hb_pc",   32'(inst_addr_out), 32'h22);
    check("hb_cyc",  32'(cycle_ct),      32'd3);
    check("hb_bct",  32'(branch_ct),     32'd0);
    ctrl_branch = 1'b0; take_branch = 1'b0; halt_req = 1'b0;
    tick();
    check("hb_hold_pc",  32'(inst_addr_out), 32'h22);
    check("hb_hold_cyc", 32'(cycle_ct),      32'd3);

    // address limit: 998, 999, then halted at 1000
    launch(16'd998);
    check("ov_pc0", 32'(inst_addr_out), 32'd998);
    tick();
    check("ov_pc1", 32'(inst_addr_out), 32'd999);
    check("ov_fv1", 32'(fetch_valid),   32'd1);
    tick();
    check("ov_pc2",   32'(inst_addr_out), 32'd1000);
    check("ov_halt2", 32'(halt),          32'd1);
    check("ov_fv2",   32'(fetch_valid),   32'd0);
    check("ov_cyc2",  32'(cycle_ct),      32'd2);
    repeat (3) tick();
    check("ov_hold_pc",   32'(inst_addr_out), 32'd1000);
    check("ov_hold_halt", 32'(halt),          32'd1);
    check("ov_hold_cyc",  32'(cycle_ct),      32'd2);

    // PC wrap 0xFFFF -> 0, then backward branch wraps past limit
    launch(16'hFFFF);
    check("wrap_fv0", 32'(fetch_valid), 32'd1);
    tick();
    check("wrap_pc", 32'(inst_addr_out), 32'h0000);
    check("wrap_fv", 32'(fetch_valid),   32'd1);
    ctrl_branch = 1'b1; take_branch = 1'b1; branch_offset = 8'hFE;
    tick();
    check("wrapbr_pc",   32'(inst_addr_out), 32'hFFFE);
    check("wrapbr_halt", 32'(halt),          32'd1);
    check("wrapbr_cyc",  32'(cycle_ct),      32'd2);
    check("wrapbr_bct",  32'(branch_ct),     br_exp(1));
    ctrl_branch = 1'b0; take_branch = 1'b0;

    // stall with pending halt, then halt, then relaunch
    launch(16'h0030);
    stall = 1'b1; halt_req = 1'b1;
    repeat (3) tick();
    check("st_pc",  32'(inst_addr_out), 32'h30);
    check("st_cyc", 32'(cycle_ct),      32'd0);
    check("st_fv",  32'(fetch_valid),   32'd1);
    stall = 1'b0;
    tick();
    check("st_halt", 32'(halt),          32'd1);
    check("st_hpc",  32'(inst_addr_out), 32'h30);
    check("st_hcyc", 32'(cycle_ct),      32'd1);
    halt_req = 1'b0;
    launch(16'h0000);
    check("rl_fv",  32'(fetch_valid),   32'd1);
    check("rl_pc",  32'(inst_addr_out), 32'h0);
    check("rl_cyc", 32'(cycle_ct),      32'd0);
    check("rl_bct", 32'(branch_ct),     32'd0);

    // reset with start in flight
    launch(16'h003B);
    repeat (7) tick();
    check("mr_pc",  32'(inst_addr_out), 32'h42);
    check("mr_cyc", 32'(cycle_ct),      32'd7);
    reset = 1'b0; start = 1'b1; start_addr = 16'h0055;
    tick();
    check("mr_fv",   32'(fetch_valid),   32'd0);
    check("mr_halt", 32'(halt),          32'd0);
    check("mr_pc0",  32'(inst_addr_out), 32'd0);
    check("mr_cyc0", 32'(cycle_ct),      32'd0);
    reset = 1'b1; start = 1'b0;
    tick();
    check("mr_idle_fv", 32'(fetch_valid),   32'd0);
    check("mr_idle_pc", 32'(inst_addr_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
